// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types: serial adder FSM states and counter sizing.
package arith_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } serial_add_state_e;

    // Bit-counter width for a WIDTH-bit serial operation; never below one bit.
    function automatic int unsigned cnt_w(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_using_half_adder.sv
// One-bit full adder built from two half-adder stages plus a carry OR.
module full_adder_using_half_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    logic ha0_s, ha0_c;
    logic ha1_s, ha1_c;

    always_comb begin
        ha0_s = a_i ^ b_i;
        ha0_c = a_i & b_i;
        ha1_s = ha0_s ^ c_i;
        ha1_c = ha0_s & c_i;
        s_o   = ha1_s;
        c_o   = ha0_c | ha1_c;
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell, LSB first, valid/ready on both sides.
module serial_adder
    import arith_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

    serial_add_state_e state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  res_q, res_d;

    logic fa_s, fa_c;

    full_adder_using_half_adder u_fa (
        .a_i (a_sh_q[0]),
        .b_i (b_sh_q[0]),
        .c_i (carry_q),
        .s_o (fa_s),
        .c_o (fa_c)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                // Result fills from the top so bit 0 ends up holding the first computed bit.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_c;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                if (cnt_q == LastBit) begin
                    cout_d  = fa_c;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        sum       = res_q;
        cout      = cout_q;
    end

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed cases with literal results plus random traffic
// checked every cycle against a transaction-level queue model.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;

    int tests = 0;
    int fails = 0;

    // Model: one expected {cout,sum} per accepted operand set, with the cycle it was accepted.
    logic [W:0] exp_q[$];
    int         acc_q[$];
    int         cyc   = 0;
    int         n_acc = 0;
    int         n_out = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Inputs change just after posedge, so negedge sees exactly what the next edge will sample.
    always @(negedge clk) begin
        logic exp_ov;
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            acc_q.delete();
        end else begin
            exp_ov = (exp_q.size() > 0) && (cyc - acc_q[0] >= W + 1);
            chk("model in_ready", 64'(in_ready), 64'(exp_q.size() == 0));
            chk("model out_valid", 64'(out_valid), 64'(exp_ov));
            if (out_valid && exp_q.size() > 0) begin
                chk("model result", 64'({cout, sum}), 64'(exp_q[0]));
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    void'(acc_q.pop_front());
                    n_out++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back((W + 1)'(a) + (W + 1)'(b) + (W + 1)'(cin));
                acc_q.push_back(cyc);
                n_acc++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_add(input string name, input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic cv, input int hold, input int poke,
                           input logic [W-1:0] es, input logic ec);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            tick();
            n++;
        end
        chk({name, " in_ready before accept"}, 64'(in_ready), 64'(1));
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = cv;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (n < poke) begin
                in_valid = 1'b1;
                a        = 8'h11;
                b        = 8'h22;
                cin      = 1'b1;
                chk({name, " in_ready during run"}, 64'(in_ready), 64'(0));
            end else begin
                in_valid = 1'b0;
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk({name, " latency"}, 64'(n), 64'(W));
        chk({name, " sum"}, 64'(sum), 64'(es));
        chk({name, " cout"}, 64'(cout), 64'(ec));
        out_ready = (hold == 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk({name, " held out_valid"}, 64'(out_valid), 64'(1));
            chk({name, " held in_ready"}, 64'(in_ready), 64'(0));
            chk({name, " held result"}, 64'({cout, sum}), 64'({ec, es}));
        end
        out_ready = 1'b1;
        tick();
        chk({name, " in_ready after transfer"}, 64'(in_ready), 64'(1));
        chk({name, " out_valid after transfer"}, 64'(out_valid), 64'(0));
    endtask

    initial begin
        int guard;
        int base_acc;
        int base_out;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        chk("reset in_ready", 64'(in_ready), 64'(1));
        chk("reset out_valid", 64'(out_valid), 64'(0));
        chk("reset sum", 64'(sum), 64'(0));
        chk("reset cout", 64'(cout), 64'(0));

        run_add("basic", 8'h35, 8'h4A, 1'b0, 0, 0, 8'h7F, 1'b0);
        run_add("wrap", 8'hFF, 8'h00, 1'b1, 0, 0, 8'h00, 1'b1);
        run_add("ones", 8'hFF, 8'hFF, 1'b1, 0, 0, 8'hFF, 1'b1);
        run_add("backpressure", 8'h80, 8'h80, 1'b0, 5, 0, 8'h00, 1'b1);
        run_add("ignored input", 8'h5A, 8'h21, 1'b1, 0, 4, 8'h7C, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no second result", 64'(out_valid), 64'(0));
        end

        // Abort an add at RUN cycle 3.
        in_valid = 1'b1;
        a        = 8'h0F;
        b        = 8'h01;
        cin      = 1'b0;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort in_ready", 64'(in_ready), 64'(1));
        chk("abort out_valid", 64'(out_valid), 64'(0));
        chk("abort sum", 64'(sum), 64'(0));
        chk("abort cout", 64'(cout), 64'(0));
        run_add("after abort", 8'h01, 8'h02, 1'b0, 0, 0, 8'h03, 1'b0);

        base_acc = n_acc;
        base_out = n_out;
        guard    = 0;
        while (n_acc - base_acc < 1000 && guard < 60000) begin
            in_valid  = ($urandom_range(3) != 0);
            a         = 8'($urandom);
            b         = 8'($urandom);
            cin       = 1'($urandom);
            out_ready = 1'($urandom);
            tick();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("random accepts", 64'(n_acc - base_acc), 64'(1000));
        guard = 0;
        while (exp_q.size() > 0 && guard < 40) begin
            tick();
            guard++;
        end
        tick();
        chk("random drain", 64'(exp_q.size()), 64'(0));
        chk("random no drops", 64'(n_out - base_out), 64'(n_acc - base_acc));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
